// File: rtl/cdc_a2s_sync_rx_if.sv
// Bundle of the bridge-side 4-phase handshake and the downstream valid/ready port
// used by the synchronous receiver of the async-to-sync CDC path.
interface cdc_a2s_sync_rx_if #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 16
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic            Si;
    logic            So;
    logic [DW-1:0]   Din;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [CNTW-1:0] fifo_count;
    logic [CW-1:0]   tok_count;

    // The receiver is the slave; the bridge and downstream consumer together form the master side.
    modport slave (
        input  Si,
        input  Din,
        input  out_ready,
        output So,
        output out_data,
        output out_valid,
        output fifo_count,
        output tok_count
    );

    modport master (
        output Si,
        output Din,
        output out_ready,
        input  So,
        input  out_data,
        input  out_valid,
        input  fifo_count,
        input  tok_count
    );
endinterface

// File: rtl/cdc_a2s_sync_rx.sv
// Synchronous-side CDC receiver: synchronizes the bridge request, acknowledges each
// token once, and buffers the bundled data in a small show-ahead FIFO.
module cdc_a2s_sync_rx #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input logic               CLK,
    input logic               RESET,
    cdc_a2s_sync_rx_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t          state_q;
    logic            si_meta_q;
    logic            si_sync_q;
    logic            so_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic [CW-1:0]   tok_q;
    logic [CW-1:0]   tok_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic full;
    logic capture;
    logic pop;

    // Full comes from the registered count, so a read on the same edge cannot admit a write.
    assign full    = (count_q == CNTW'(DEPTH));
    assign capture = (state_q == IDLE) && si_sync_q && !full;
    assign pop     = (count_q != '0) && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tok_d    = tok_q;
        if (capture) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            tok_d    = tok_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({capture, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            si_meta_q <= 1'b0;
            si_sync_q <= 1'b0;
        end else begin
            si_meta_q <= bus.Si;
            si_sync_q <= si_meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            so_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        so_q    <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!si_sync_q) begin
                        so_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    so_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tok_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tok_q    <= tok_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge CLK) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= bus.Din;
        end
    end

    assign bus.So         = so_q;
    assign bus.out_data   = mem_q[rd_ptr_q];
    assign bus.out_valid  = (count_q != '0);
    assign bus.fifo_count = count_q;
    assign bus.tok_count  = tok_q;

    assert property (@(posedge CLK) disable iff (RESET) count_q <= CNTW'(DEPTH));
    assert property (@(posedge CLK) disable iff (RESET) (state_q == ACK) == so_q);
endmodule
